// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  // Default number of bits retired per CALC cycle.
  localparam int MDU_BPC = 1;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// Combinational block performing BPC restoring-division steps on
// {remainder, quotient}. The quotient register initially holds the dividend
// and receives quotient bits from the right as dividend bits shift out.
module mdu_div_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quo;

  // Unrolled shift / trial-subtract / restore chain.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is
    // inferred; blocking assignments let each unrolled step see the previous one.
    w_shift = '0;
    w_rem   = i_rem;
    w_quo   = i_quo;
    for (int k = 0; k < BPC; k++) begin
      // One extra bit: the shifted remainder can reach 2*divisor-1.
      w_shift = {w_rem, w_quo[XLEN-1]};
      w_quo   = {w_quo[XLEN-2:0], 1'b0};
      if (w_shift >= {1'b0, i_div}) begin
        w_shift  = w_shift - {1'b0, i_div};
        w_quo[0] = 1'b1;
      end
      w_rem = w_shift[XLEN-1:0];
    end
    o_rem = w_rem;
    o_quo = w_quo;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes and flush.
// Multiplies retire BPC multiplier bits per cycle into a 2*XLEN accumulator;
// divides run BPC restoring steps per cycle on operand magnitudes.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = MDU_BPC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c_out,
  output logic            busy
);

  localparam int ITERS = XLEN / BPC;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  mdu_state_t        r_state, w_state_nxt;
  mdu_op_t           r_op, w_op;
  logic [CW-1:0]     r_cnt;
  // Multiply: r_acc is the product, r_mcand the shifting multiplicand.
  // Divide: r_acc is {remainder, quotient}, r_mcand[XLEN-1:0] the divisor.
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [2*XLEN-1:0] w_mul_nxt, w_acc_nxt, w_init_acc, w_init_mcand;
  logic [XLEN-1:0]   r_mplier, r_c_out;
  logic              r_neg_q, r_neg_r;
  logic              w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_special;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_calc_res;

  assign w_op     = mdu_op_t'(funct3);
  assign w_is_div = funct3[2];
  assign w_a_sgn  = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_sgn  = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg  = w_a_sgn & a_in[XLEN-1];
  assign w_b_neg  = w_b_sgn & b_in[XLEN-1];
  assign w_a_mag  = w_a_neg ? -a_in : a_in;
  assign w_b_mag  = w_b_neg ? -b_in : b_in;

  assign in_ready  = (r_state == IDLE) & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign c_out     = r_c_out;

  // Divide-by-zero and signed-overflow results, bypassing CALC.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (w_is_div) begin
      if (b_in == '0) begin
        w_special     = 1'b1;
        w_special_res = funct3[1] ? a_in : '1;
      end else if (!funct3[0] && (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1)) begin
        w_special     = 1'b1;
        w_special_res = funct3[1] ? '0 : a_in;
      end
    end
  end

  // Initial datapath contents at accept. A signed negative multiplier adds
  // -a_ext * 2^XLEN up front so only its low XLEN bits need iterating.
  always_comb begin
    if (w_is_div) begin
      w_init_acc   = {{XLEN{1'b0}}, w_a_mag};
      w_init_mcand = {{XLEN{1'b0}}, w_b_mag};
    end else begin
      w_init_mcand = {{XLEN{w_a_neg}}, a_in};
      w_init_acc   = w_b_neg ? -{a_in, {XLEN{1'b0}}} : '0;
    end
  end

  // Accumulate BPC partial products for one multiply iteration.
  always_comb begin
    w_mul_nxt = r_acc;
    for (int k = 0; k < BPC; k++) begin
      if (r_mplier[k]) w_mul_nxt = w_mul_nxt + (r_mcand << k);
    end
  end

  mdu_div_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_div_step (
    .i_rem (r_acc[2*XLEN-1:XLEN]),
    .i_quo (r_acc[XLEN-1:0]),
    .i_div (r_mcand[XLEN-1:0]),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  assign w_acc_nxt = r_op[2] ? {w_rem_nxt, w_quo_nxt} : w_mul_nxt;

  // Final result selection with sign correction, used on the last CALC cycle.
  always_comb begin
    case (r_op)
      OP_MUL:                       w_calc_res = w_acc_nxt[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_acc_nxt[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_calc_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      default:                      w_calc_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
        CALC:    if (r_cnt == '0) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_c_out  <= '0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_cnt    <= CW'(ITERS - 1);
      r_acc    <= w_init_acc;
      r_mcand  <= w_init_mcand;
      r_mplier <= b_in;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_special) r_c_out <= w_special_res;
    end else if ((r_state == CALC) && !flush) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier >> BPC;
      r_cnt    <= r_cnt - 1'b1;
      if (!r_op[2]) r_mcand <= r_mcand << BPC;
      if (r_cnt == '0) r_c_out <= w_calc_res;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: three instances (BPC = 1, 2, 4) share one
// stimulus stream; a monitor compares each result and its latency.
module tb_mdu_iter;

  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              flush;
  logic              out_ready;
  logic [2:0]        funct3;
  logic [31:0]       a_in;
  logic [31:0]       b_in;
  logic [N-1:0]      in_ready_v;
  logic [N-1:0]      out_valid_v;
  logic [N-1:0]      busy_v;
  logic [N-1:0][31:0] c_out_v;

  typedef struct {
    string       name;
    logic [31:0] res;
    bit          special;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx[N];
  logic [31:0] cur_res[N];
  bit          cur_ok[N];
  int          cyc = 0;
  int          n_err = 0;
  int          n_chk = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mdu_iter #(
      .XLEN (32),
      .BPC  (1 << g)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .funct3    (funct3),
      .a_in      (a_in),
      .b_in      (b_in),
      .flush     (flush),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .c_out     (c_out_v[g]),
      .busy      (busy_v[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Pops one expectation per DUT on the first cycle of out_valid, checks the
  // latency, then checks c_out on every cycle the result is held.
  task automatic monitor();
    bit [N-1:0] seen;
    exp_t       e;
    int         lat_exp;
    seen = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        if (!rst_n || !out_valid_v[d]) begin
          seen[d] = 1'b0;
        end else begin
          if (!seen[d]) begin
            seen[d] = 1'b1;
            if (rd_idx[d] < exp_q.size()) begin
              e          = exp_q[rd_idx[d]];
              cur_res[d] = e.res;
              cur_ok[d]  = 1'b1;
              rd_idx[d]++;
              lat_exp    = e.special ? 1 : (32 / (1 << d)) + 1;
              check($sformatf("%s/bpc%0d latency", e.name, 1 << d), 32'(cyc - e.acc_cyc), 32'(lat_exp));
            end else begin
              n_chk++;
              n_err++;
              cur_ok[d] = 1'b0;
              $display("FAIL unexpected_output/bpc%0d: got out_valid=1 c_out=0x%08h required no result pending",
                       1 << d, c_out_v[d]);
            end
          end
          if (cur_ok[d]) check($sformatf("c_out/bpc%0d", 1 << d), c_out_v[d], cur_res[d]);
        end
      end
    end
  endtask

  // Waits (bounded) for all DUTs to be ready, then presents one request.
  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input bit sp, input bit push);
    int t = 0;
    while (in_ready_v != '1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (in_ready_v != '1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s ready_timeout: got in_ready=%b required 111", name, in_ready_v);
      return;
    end
    funct3   = f;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    if (push) exp_q.push_back('{name: name, res: res, special: sp, acc_cyc: cyc});
    @(negedge clk);
    // Scramble the operand buses to prove they were captured at accept.
    in_valid = 1'b0;
    funct3   = 3'd7;
    a_in     = 32'hDEAD_BEEF;
    b_in     = 32'h1234_5678;
  endtask

  task automatic drain(input string name);
    int t = 0;
    bit ok = 1'b0;
    while (t < 400) begin
      ok = (in_ready_v == '1);
      for (int d = 0; d < N; d++) if (rd_idx[d] != exp_q.size()) ok = 1'b0;
      if (ok) break;
      @(negedge clk);
      t++;
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL %s drain_timeout: got in_ready=%b required all results delivered", name, in_ready_v);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    funct3    = 3'd0;
    a_in      = '0;
    b_in      = '0;
    for (int d = 0; d < N; d++) begin
      rd_idx[d]  = 0;
      cur_res[d] = '0;
      cur_ok[d]  = 1'b0;
    end
    fork
      monitor();
    join_none

    // Reset state.
    #2;
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst out_valid/bpc%0d", 1 << d), 32'(out_valid_v[d]), 32'd0);
      check($sformatf("rst c_out/bpc%0d", 1 << d), c_out_v[d], 32'd0);
      check($sformatf("rst busy/bpc%0d", 1 << d), 32'(busy_v[d]), 32'd0);
      check($sformatf("rst in_ready/bpc%0d", 1 << d), 32'(in_ready_v[d]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: funct3 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU.
    issue("mul_7x6",      3'd0, 32'd7,        32'd6,        32'd42,       1'b0, 1'b1);
    issue("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);
    issue("mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b1);
    issue("mulhsu_m1x2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b1);
    issue("mulh_m1xm1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    issue("mul_m3x5",     3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 1'b1);
    issue("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b1);
    issue("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b1);
    issue("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       1'b0, 1'b1);
    issue("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        1'b0, 1'b1);
    issue("divu_by0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b1);
    issue("remu_by0",     3'd7, 32'd9,        32'd0,        32'd9,        1'b1, 1'b1);
    issue("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b1);
    issue("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
    drain("vectors");

    // Back-pressure: result must hold in DONE while out_ready is low.
    out_ready = 1'b0;
    issue("stall_divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    for (int t = 0; t < 100 && out_valid_v != '1; t++) @(negedge clk);
    check("stall out_valid", 32'(out_valid_v), 32'h7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        check($sformatf("stall in_ready/bpc%0d", 1 << d), 32'(in_ready_v[d]), 32'd0);
        check($sformatf("stall out_valid/bpc%0d", 1 << d), 32'(out_valid_v[d]), 32'd1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready_v), 32'h7);
    check("release out_valid", 32'(out_valid_v), 32'h0);

    // Flush mid-CALC: the aborted operation must never produce a result.
    issue("flushed_mul", 3'd0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready_v), 32'h0);
    check("flush busy", 32'(busy_v), 32'h7);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post_flush in_ready", 32'(in_ready_v), 32'h7);
    check("post_flush out_valid", 32'(out_valid_v), 32'h0);
    check("post_flush busy", 32'(busy_v), 32'h0);
    // Flush in IDLE blocks acceptance of a simultaneous request.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    funct3   = 3'd0;
    a_in     = 32'd2;
    b_in     = 32'd2;
    #1;
    check("idle_flush in_ready", 32'(in_ready_v), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("idle_flush not_accepted", 32'(busy_v), 32'h0);
    @(negedge clk);
    issue("mul_3x3", 3'd0, 32'd3, 32'd3, 32'd9, 1'b0, 1'b1);
    drain("flush");

    // Asynchronous reset in the middle of CALC clears outputs at once.
    issue("reset_mul", 3'd0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("midrst c_out/bpc%0d", 1 << d), c_out_v[d], 32'd0);
      check($sformatf("midrst out_valid/bpc%0d", 1 << d), 32'(out_valid_v[d]), 32'd0);
      check($sformatf("midrst busy/bpc%0d", 1 << d), 32'(busy_v[d]), 32'd0);
      check($sformatf("midrst in_ready/bpc%0d", 1 << d), 32'(in_ready_v[d]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("remu_after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
    drain("final");

    for (int d = 0; d < N; d++)
      check($sformatf("results_delivered/bpc%0d", 1 << d), 32'(rd_idx[d]), 32'(exp_q.size()));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
